ip_crpr_gen: RTL and testbench
==============================

Name: ip_crpr_gen

Overview:
- Source end of the credit-return interface. Converts "TLP consumed" events from the RX application logic into header and data credit-return pulses.
- Output format is pd_cr/pd_num/ph_cr/npd_cr/nph_cr, so two instances can feed the downstream two-port credit-return arbiter.
- Guarantees the arbiter's input contract: at least one idle cycle between pulses on a channel, and data credits only alongside a header credit.

Parameters:
- CNT_W, 12, width of each pending-credit accumulator.
- PD_MAX, 255, maximum posted data credits per pulse; fixed by the 8-bit pd_num.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tlp_done  in  1  one-cycle pulse: one RX TLP fully consumed
- tlp_type  in  2  00 posted, 01 non-posted, 10 completion, 11 reserved
- tlp_len_dw  in  11  payload length in DW; 0 = no payload
- cr_en  in  1  1 = pulses may be issued; 0 = accumulate only
- pd_cr  out  1  posted data credit return valid
- pd_num  out  8  posted data credits returned
- ph_cr  out  1  one posted header credit returned
- npd_cr  out  1  one non-posted data credit returned
- nph_cr  out  1  one non-posted header credit returned
- cr_err  out  1  sticky error flag

Behaviour:
- Reset: synchronous, active-high, on the clk edge. All outputs are 0, all accumulators 0, gap flags 0, cr_err 0.
- Credit conversion on tlp_done (one credit = 4 DW):
  - Posted: ph_pend += 1; pd_pend += ceil(tlp_len_dw/4).
  - Non-posted: nph_pend += 1; npd_pend += 1 if tlp_len_dw != 0.
  - Completion and reserved types: ignored, no credits.
- Length limits:
  - Posted tlp_len_dw > 1020: data credits clamp to 255 and cr_err sets. This keeps the invariant pd_pend <= 255*ph_pend.
  - Non-posted tlp_len_dw > 1: counts 1 credit and sets cr_err.
- Accumulators update at the edge ending the tlp_done cycle.
  - Increment and decrement in the same cycle apply net.
  - Overflow past 2^CNT_W-1 saturates and sets cr_err.
- Posted channel issue rule. In any cycle where cr_en=1, ph_pend>0 and ph_cr is currently 0, the next edge registers:
  - ph_cr=1;
  - pd_num=min(pd_pend,PD_MAX);
  - pd_cr=(pd_num!=0);
  - ph_pend-=1 and pd_pend-=pd_num, at the same edge.
- Posted outputs otherwise: all 0, with pd_num=0.
- Non-posted channel: same rule. nph_cr=1, npd_cr=(npd_pend>0), nph_pend-=1, npd_pend-=npd_cr.
- Rate and independence:
  - A channel never pulses on two consecutive cycles, so its maximum rate is one header per two cycles.
  - The two channels are independent and may pulse in the same cycle.
- Invariants: pd_pend never nonzero with ph_pend=0; npd_pend <= nph_pend. Data is never emitted without a header.
- Latency: tlp_done in cycle N gives the earliest pulse in cycle N+2 (cr_en=1, channel idle in N+1).
- cr_en deasserted:
  - Pulses stop starting from the next edge; accumulation continues.
  - A pulse already registered completes its single cycle.
- Reset mid-operation discards all pending credits. This is intended: link-level reset re-initialises credits.
- cr_err is cleared only by rst.

Decomposition:
- Shared package ip_crpr_pkg: TLP type encodings (TLP_P, TLP_NP, TLP_CPL), CR_DW_PER_CREDIT=4, PD_MAX=255, MAX_P_LEN_DW=1020.
- Sub-module ip_crpr_chan: one channel.
  - Contents: header/data accumulators, gap flag, issue register.
  - Parameter DATA_W: 8 for posted, 1 for non-posted.
  - Instantiated twice.
- Top level: length-to-credit conversion, type decode, cr_err.

Test Plan:
- Posted, len 10 DW, cr_en=1, tlp_done at cycle 0 -> cycle 2: ph_cr=1, pd_cr=1, pd_num=3; cycle 3 all 0.
- Three posted, len 0, on consecutive cycles 0-2 -> ph_cr pulses in cycles 2, 4, 6, with pd_cr=0 each time; never back-to-back.
- Posted len 1020 then posted len 1020 -> pulses with pd_num=255 then 255; pd_pend ends at 0; cr_err=0.
- Posted len 1024 -> pd_num=255 and cr_err=1 sticky; non-posted len 1 in the same stream -> nph_cr=1 and npd_cr=1, independent of posted timing.
- cr_en=0 while 4 posted (len 8) and 2 non-posted (len 0) are consumed, then cr_en=1 -> 4 ph_cr pulses each with pd_num=2 (one every 2 cycles), 2 nph_cr pulses with npd_cr=0.
- rst asserted for 1 cycle with ph_pend=3 -> all outputs 0 from the next cycle; no further pulses; cr_err=0.

Source files
------------

// File: rtl/ip_crpr_pkg.sv
// ip_crpr_pkg: shared TLP encodings and credit-conversion constants
package ip_crpr_pkg;
  typedef enum logic [1:0] {TLP_P = 2'b00, TLP_NP = 2'b01, TLP_CPL = 2'b10, TLP_RSV = 2'b11} tlp_type_e;
  localparam int CR_DW_PER_CREDIT = 4;
  localparam int PD_MAX = 255;
  localparam int MAX_P_LEN_DW = 1020;
endpackage

// File: rtl/ip_crpr_chan.sv
// ip_crpr_chan: one credit channel, pending header/data accumulators and paced pulse issue
// Ports: clk, rst; cr_en_i enables issue; hdr_inc_i/data_inc_i add pending credits;
//        hdr_cr_o/data_cr_o/data_num_o are the registered pulse; ovf_o flags accumulator saturation.
module ip_crpr_chan #(
  parameter int CNT_W  = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cr_en_i,
  input  logic              hdr_inc_i,
  input  logic [DATA_W-1:0] data_inc_i,
  output logic              hdr_cr_o,
  output logic              data_cr_o,
  output logic [DATA_W-1:0] data_num_o,
  output logic              ovf_o
);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'((1 << DATA_W) - 1);
  logic [CNT_W-1:0]  hdr_q, hdr_d, dat_q, dat_d;
  logic [CNT_W:0]    hdr_s, dat_s;
  logic              cr_q, cr_d;
  logic [DATA_W-1:0] num_q, num_d;
  // issue is blocked while a pulse is on the output, forcing an idle cycle between pulses
  always_comb begin
    cr_d  = cr_en_i && hdr_q != '0 && !cr_q;
    num_d = !cr_d ? '0 : dat_q > DMAX ? DMAX[DATA_W-1:0] : dat_q[DATA_W-1:0];
    hdr_s = {1'b0, hdr_q} + (CNT_W+1)'(hdr_inc_i) - (CNT_W+1)'(cr_d);
    dat_s = {1'b0, dat_q} + (CNT_W+1)'(data_inc_i) - (CNT_W+1)'(num_d);
    hdr_d = hdr_s[CNT_W] ? '1 : hdr_s[CNT_W-1:0];
    dat_d = dat_s[CNT_W] ? '1 : dat_s[CNT_W-1:0];
    ovf_o = hdr_s[CNT_W] | dat_s[CNT_W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q <= '0;
      dat_q <= '0;
      cr_q  <= 1'b0;
      num_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      dat_q <= dat_d;
      cr_q  <= cr_d;
      num_q <= num_d;
    end
  end
  assign hdr_cr_o   = cr_q;
  assign data_num_o = num_q;
  assign data_cr_o  = |num_q;
endmodule

// File: rtl/ip_crpr_gen.sv
// ip_crpr_gen: converts consumed-TLP events into paced posted/non-posted credit-return pulses
// Ports: clk, rst; tlp_done/tlp_type/tlp_len_dw describe a consumed TLP; cr_en gates issue;
//        pd_cr/pd_num/ph_cr posted returns; npd_cr/nph_cr non-posted returns; cr_err sticky error.
module ip_crpr_gen import ip_crpr_pkg::*; #(
  parameter int CNT_W  = 12,
  parameter int PD_MAX = ip_crpr_pkg::PD_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlp_done,
  input  logic [1:0]  tlp_type,
  input  logic [10:0] tlp_len_dw,
  input  logic        cr_en,
  output logic        pd_cr,
  output logic [7:0]  pd_num,
  output logic        ph_cr,
  output logic        npd_cr,
  output logic        nph_cr,
  output logic        cr_err
);
  logic       p_done, np_done, p_long, np_long, p_ovf, np_ovf, cr_err_q, cr_err_d;
  logic [7:0] pd_inc;
  logic       npd_inc;
  // clamping long posted TLPs to one pulse's worth keeps pd_pend <= PD_MAX*ph_pend
  always_comb begin
    p_done   = tlp_done && tlp_type == TLP_P;
    np_done  = tlp_done && tlp_type == TLP_NP;
    p_long   = p_done && tlp_len_dw > 11'(MAX_P_LEN_DW);
    np_long  = np_done && tlp_len_dw > 11'd1;
    pd_inc   = !p_done ? '0 : p_long ? 8'(PD_MAX) :
               8'((12'(tlp_len_dw) + 12'(CR_DW_PER_CREDIT - 1)) / 12'(CR_DW_PER_CREDIT));
    npd_inc  = np_done && tlp_len_dw != '0;
    cr_err_d = cr_err_q | p_long | np_long | p_ovf | np_ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) cr_err_q <= 1'b0;
    else     cr_err_q <= cr_err_d;
  end
  assign cr_err = cr_err_q;
  ip_crpr_chan #(.CNT_W(CNT_W), .DATA_W(8)) u_p (
    .clk(clk), .rst(rst), .cr_en_i(cr_en), .hdr_inc_i(p_done), .data_inc_i(pd_inc),
    .hdr_cr_o(ph_cr), .data_cr_o(pd_cr), .data_num_o(pd_num), .ovf_o(p_ovf)
  );
  ip_crpr_chan #(.CNT_W(CNT_W), .DATA_W(1)) u_np (
    .clk(clk), .rst(rst), .cr_en_i(cr_en), .hdr_inc_i(np_done), .data_inc_i(npd_inc),
    .hdr_cr_o(nph_cr), .data_cr_o(npd_cr), .data_num_o(), .ovf_o(np_ovf)
  );
endmodule

// File: tb/tb_ip_crpr_gen.sv
// tb_ip_crpr_gen: scoreboard bench with a cycle-level credit model and randomized traffic
module tb_ip_crpr_gen;
  logic        clk = 1'b0, rst, tlp_done, cr_en;
  logic [1:0]  tlp_type;
  logic [10:0] tlp_len_dw;
  logic        pd_cr, ph_cr, npd_cr, nph_cr, cr_err;
  logic [7:0]  pd_num;

  ip_crpr_gen dut (
    .clk(clk), .rst(rst), .tlp_done(tlp_done), .tlp_type(tlp_type), .tlp_len_dw(tlp_len_dw),
    .cr_en(cr_en), .pd_cr(pd_cr), .pd_num(pd_num), .ph_cr(ph_cr), .npd_cr(npd_cr),
    .nph_cr(nph_cr), .cr_err(cr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pd_num;
    logic pd_cr, ph_cr, npd_cr, nph_cr, err;
  } exp_t;

  exp_t q[$];
  int passed = 0, total = 0, cyc_n = 0;
  int ph = 0, pd = 0, nph = 0, npd = 0;
  bit ph_o = 0, nph_o = 0, err = 0;

  function automatic int sat(input int x, inout bit e);
    if (x > 4095) begin
      e = 1;
      return 4095;
    end
    return x;
  endfunction

  task automatic cyc(input bit r, input bit d, input int t, input int len, input bit en);
    exp_t e;
    int pn;
    bit pg, ng, nd;
    rst = r; tlp_done = d; tlp_type = 2'(t); tlp_len_dw = 11'(len); cr_en = en;
    if (r) begin
      ph = 0; pd = 0; nph = 0; npd = 0; ph_o = 0; nph_o = 0; err = 0;
      e = '0;
    end else begin
      pg = en && ph > 0 && !ph_o;
      pn = pg ? (pd < 255 ? pd : 255) : 0;
      ng = en && nph > 0 && !nph_o;
      nd = ng && npd > 0;
      ph -= int'(pg); pd -= pn; nph -= int'(ng); npd -= int'(nd);
      if (d && t == 0) begin
        ph += 1;
        pd += len > 1020 ? 255 : (len + 3) / 4;
        if (len > 1020) err = 1;
      end
      if (d && t == 1) begin
        nph += 1;
        npd += int'(len != 0);
        if (len > 1) err = 1;
      end
      ph = sat(ph, err); pd = sat(pd, err); nph = sat(nph, err); npd = sat(npd, err);
      ph_o = pg; nph_o = ng;
      e = '{8'(pn), pn != 0, pg, nd, ng, err};
    end
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, en);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    cyc_n++;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = '{pd_num, pd_cr, ph_cr, npd_cr, nph_cr, cr_err};
      total++;
      if (a === e) passed++;
      else $display("FAIL outputs cycle %0d: got pd_num=%0d pd_cr=%b ph_cr=%b npd_cr=%b nph_cr=%b cr_err=%b, want pd_num=%0d pd_cr=%b ph_cr=%b npd_cr=%b nph_cr=%b cr_err=%b",
                    cyc_n, a.pd_num, a.pd_cr, a.ph_cr, a.npd_cr, a.nph_cr, a.err,
                    e.pd_num, e.pd_cr, e.ph_cr, e.npd_cr, e.nph_cr, e.err);
    end
  end

  initial begin
    int t, len;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 10, 1);
    idle(4, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1);
    idle(8, 1);
    cyc(0, 1, 0, 1020, 1);
    cyc(0, 1, 0, 1020, 1);
    idle(6, 1);
    cyc(0, 1, 0, 1024, 1);
    cyc(0, 1, 1, 1, 1);
    idle(6, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8, 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, 1, 0, 0);
    idle(12, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16, 0);
    cyc(1, 0, 0, 0, 1);
    idle(6, 1);
    for (int i = 0; i < 3000; i++) begin
      t = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: len = $urandom_range(0, 16);
        1: len = $urandom_range(0, 1020);
        2: len = $urandom_range(1021, 2047);
        default: len = $urandom_range(0, 2);
      endcase
      cyc(0, $urandom_range(0, 2) != 0, t, len, $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 999) == 0) cyc(1, 0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4100; i++) cyc(0, 1, i % 2, 1020, 0);
    idle(20, 1);
    cyc(1, 0, 0, 0, 1);
    idle(4, 1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
